draw_scheduler: RTL

//  Sequences the per-layer draw engines (background, gold/stone, hook, gameover, ...) once per frame.

---
 rtl/draw_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// Per-frame draw sequencer: launches each enabled layer engine in priority order and muxes its pixel port.
// Optional per-layer watchdog is built when DRAW_SCHED_WATCHDOG_EN is defined.
module draw_scheduler #(
  parameter int N_LAYERS  = 4,
  parameter int WD_CYCLES = 20000,
  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_tick,
  input  logic [N_LAYERS-1:0]     layer_mask,
  input  logic [9*N_LAYERS-1:0]   X_in,
  input  logic [8*N_LAYERS-1:0]   Y_in,
  input  logic [12*N_LAYERS-1:0]  Color_in,
  input  logic [N_LAYERS-1:0]     writeEn_in,
  input  logic [N_LAYERS-1:0]     done_in,
  output logic [N_LAYERS-1:0]     enable_draw,
  output logic [8:0]              X_out,
  output logic [7:0]              Y_out,
  output logic [11:0]             Color_out,
  output logic                    writeEn_out,
  output logic [LW-1:0]           cur_layer,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    wd_err
);

  localparam int IW = $clog2(N_LAYERS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [N_LAYERS-1:0]   mask_q, mask_d;
  logic                  pending_q, pending_d;
  logic [8:0]            x_q, x_d;
  logic [7:0]            y_q, y_d;
  logic [11:0]           c_q, c_d;
  logic                  we_q, we_d;

  logic [LW-1:0]         lidx;
  logic                  selMask, selWe, selDone;
  logic [8:0]            selX;
  logic [7:0]            selY;
  logic [11:0]           selC;
  logic                  wdHit;

  assign lidx = idx_q[LW-1:0];

  // Pick out the slice belonging to the layer currently being scheduled.
  always_comb begin
    selMask = 1'b0;
    selWe   = 1'b0;
    selDone = 1'b0;
    selX    = '0;
    selY    = '0;
    selC    = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (lidx == LW'(i)) begin
        selMask = mask_q[i];
        selWe   = writeEn_in[i];
        selDone = done_in[i];
        selX    = X_in[9*i +: 9];
        selY    = Y_in[8*i +: 8];
        selC    = Color_in[12*i +: 12];
      end
    end
  end

`ifdef DRAW_SCHED_WATCHDOG_EN
  localparam int WDW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

  logic [WDW-1:0] wdCnt_q, wdCnt_d;
  logic           wdErr_q, wdErr_d;

  assign wdHit = (state_q == S_WAIT) && (wdCnt_q == WDW'(WD_CYCLES - 1));

  always_comb begin
    wdCnt_d = wdCnt_q;
    wdErr_d = wdErr_q | wdHit;
    if (state_q == S_LAUNCH) begin
      wdCnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wdCnt_d = wdCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdCnt_q <= '0;
      wdErr_q <= 1'b0;
    end else begin
      wdCnt_q <= wdCnt_d;
      wdErr_q <= wdErr_d;
    end
  end

  assign wd_err = wdErr_q;
`else
  assign wdHit  = 1'b0;
  assign wd_err = 1'b0;
`endif

  // Next-state logic; a tick arriving mid-frame is remembered once and replayed from IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    pending_d = pending_q;
    x_d       = x_q;
    y_d       = y_q;
    c_d       = c_q;
    we_d      = 1'b0;
    if ((state_q != S_IDLE) && frame_tick) begin
      pending_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (frame_tick || pending_q) begin
          mask_d    = layer_mask;
          idx_d     = '0;
          pending_d = 1'b0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (idx_q == IW'(N_LAYERS)) begin
          state_d = S_DONE;
        end else if (selMask) begin
          state_d = S_LAUNCH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        x_d  = selX;
        y_d  = selY;
        c_d  = selC;
        we_d = selWe;
        if (selDone || wdHit) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      pending_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      c_q       <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c_q       <= c_d;
      we_q      <= we_d;
    end
  end

  assign enable_draw = (state_q == S_LAUNCH) ? ({{(N_LAYERS-1){1'b0}}, 1'b1} << lidx) : '0;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign cur_layer   = lidx;
  assign X_out       = x_q;
  assign Y_out       = y_q;
  assign Color_out   = c_q;
  assign writeEn_out = we_q;

endmodule
